// File: rtl/f1_race_ctrl.sv
// f1_race_ctrl: sequencer wrapped around the F1 start-light FSM.
// It paces the light build-up from a divided tick, holds all lights on for a
// pseudo-random number of ticks, then triggers lights-out. After that it
// measures the driver's reaction time in clock cycles until stop arrives.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous reset, active low
//   start          race start request, one-cycle pulse
//   stop           driver reaction button, one-cycle pulse
//   cmd_seq        light FSM: build-up in progress
//   cmd_delay      light FSM: all 8 lights on
//   light_en       light FSM enable
//   light_trigger  light FSM step trigger, one-cycle pulse
//   light_rst      light FSM reset, active high
//   busy           controller is not idle
//   rt_valid       one-cycle pulse, rt_value just updated
//   rt_value       last measured reaction time in clock cycles
//   jump_start     sticky flag: stop arrived before lights-out
//
// States:
//   state    | meaning
//   S_IDLE   | waiting for start
//   S_SEQ    | lights building up, one trigger per tick
//   S_DELAY  | all lights on, counting down the random delay
//   S_TIMING | lights out, counting reaction cycles
//   S_FAULT  | jump start: reset the light FSM for one cycle

module f1_race_ctrl #(
  parameter int TICK_DIV = 24,
  parameter int RT_W     = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stop,
  input  logic            cmd_seq,
  input  logic            cmd_delay,
  output logic            light_en,
  output logic            light_trigger,
  output logic            light_rst,
  output logic            busy,
  output logic            rt_valid,
  output logic [RT_W-1:0] rt_value,
  output logic            jump_start
);

  localparam int              TW        = $clog2(TICK_DIV);
  localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [RT_W-1:0] RT_MAX    = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEQ,
    S_DELAY,
    S_TIMING,
    S_FAULT
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [6:0]      delay_q, delay_d;
  logic [RT_W-1:0] rt_cnt_q, rt_cnt_d;
  logic [6:0]      lfsr_q, lfsr_d;

  logic            light_en_q, light_en_d;
  logic            trig_q, trig_d;
  logic            light_rst_q, light_rst_d;
  logic            busy_q, busy_d;
  logic            rt_valid_q, rt_valid_d;
  logic [RT_W-1:0] rt_value_q, rt_value_d;
  logic            jump_q, jump_d;

  logic            tick_hit;

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    delay_d    = delay_q;
    rt_cnt_d   = rt_cnt_q;
    rt_value_d = rt_value_q;
    jump_d     = jump_q;
    rt_valid_d = 1'b0;

    // x^7 + x^6 + 1, shift left with feedback into bit 0; all-zero is unreachable
    lfsr_d   = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
    tick_hit = (tick_q == TICK_LAST);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SEQ;
          jump_d  = 1'b0;
        end
      end
      S_SEQ: begin
        if (stop) begin
          state_d = S_FAULT;
          jump_d  = 1'b1;
        end else if (cmd_delay && !cmd_seq && !trig_q) begin
          // both light-FSM flags agree the build-up is complete and no
          // step is still in flight
          state_d = S_DELAY;
          delay_d = lfsr_q;
        end
      end
      S_DELAY: begin
        if (stop) begin
          state_d = S_FAULT;
          jump_d  = 1'b1;
        end else if (trig_q) begin
          state_d  = S_TIMING;
          rt_cnt_d = '0;
        end else if (tick_hit) begin
          // delay_q is at least 2 here: the tick with delay_q==1 carries trig_q
          delay_d = delay_q - 7'd1;
        end
      end
      S_TIMING: begin
        if (stop) begin
          rt_value_d = rt_cnt_q;
          rt_valid_d = 1'b1;
          state_d    = S_IDLE;
        end else if (rt_cnt_q != RT_MAX) begin
          rt_cnt_d = rt_cnt_q + 1'b1;
        end
      end
      S_FAULT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d != state_q) begin
      tick_d = '0;
    end else if (state_q == S_SEQ || state_q == S_DELAY) begin
      tick_d = tick_hit ? '0 : tick_q + 1'b1;
    end

    // Outputs are registered, so they are derived from the next state. The
    // trigger is high in the same cycle that tick_q sits at its last value.
    trig_d      = ((state_d == S_SEQ)   && (tick_d == TICK_LAST)) ||
                  ((state_d == S_DELAY) && (tick_d == TICK_LAST) && (delay_d == 7'd1));
    light_en_d  = (state_d == S_SEQ) || (state_d == S_DELAY);
    light_rst_d = (state_d == S_FAULT);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      tick_q      <= '0;
      delay_q     <= '0;
      rt_cnt_q    <= '0;
      lfsr_q      <= 7'h01;
      light_en_q  <= 1'b0;
      trig_q      <= 1'b0;
      light_rst_q <= 1'b1;
      busy_q      <= 1'b0;
      rt_valid_q  <= 1'b0;
      rt_value_q  <= '0;
      jump_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      delay_q     <= delay_d;
      rt_cnt_q    <= rt_cnt_d;
      lfsr_q      <= lfsr_d;
      light_en_q  <= light_en_d;
      trig_q      <= trig_d;
      light_rst_q <= light_rst_d;
      busy_q      <= busy_d;
      rt_valid_q  <= rt_valid_d;
      rt_value_q  <= rt_value_d;
      jump_q      <= jump_d;
    end
  end

  assign light_en      = light_en_q;
  assign light_trigger = trig_q;
  assign light_rst     = light_rst_q;
  assign busy          = busy_q;
  assign rt_valid      = rt_valid_q;
  assign rt_value      = rt_value_q;
  assign jump_start    = jump_q;

endmodule
